pipe_hazard_ctrl: RTL and testbench
===================================

// Module: pipe_hazard_ctrl
// PURPOSE
//  Central stall/flush/redirect sequencer for the 5-stage pipeline. Merges the ID-stage
//  load-use bubble request, ID jumps/exceptions, EX branch resolution and memory wait into
//  one set of per-cycle pipeline-register controls. Owns interrupt entry: latches the
//  external IRQ, drains in-flight control flow, then injects exactly one IRQ into ID.
//  Keeps saturating-free stall/flush performance counters.
// PARAMETERS
//  DRAIN_CYCLES  2   consecutive redirect-free cycles required before IRQ injection (>=1)
//  CNT_W         32  width of performance counters
// PORTS
//  clk             in   1      clock; all state updates on rising edge
//  reset           in   1      synchronous, active-high reset
//  load_use        in   1      ID load-use hazard (bubble request)
//  id_jump         in   1      ID decodes j/jal/jr/jalr
//  id_exception    in   1      ID decodes undefined instruction
//  ex_branch_taken in   1      EX resolved conditional branch as taken
//  mem_busy        in   1      data memory not ready; whole pipe must freeze
//  irq_req         in   1      external interrupt request, level
//  kernel_mode     in   1      PC[31] of the instruction in IF (1 = kernel)
//  pc_write        out  1      PC register load enable
//  if_id_write     out  1      IF/ID register load enable
//  if_flush        out  1      zero IF/ID on next edge
//  id_flush        out  1      zero ID/EX on next edge (bubble)
//  irq_to_id       out  1      IRQ strobe into ID control decode
//  irq_pending     out  1      IRQ latched, not yet injected
//  stall_count     out  CNT_W  cycles with pc_write=0 (excl. reset)
//  flush_count     out  CNT_W  cycles with if_flush=1 (excl. reset)
// BEHAVIOUR
//  - Control outputs are combinational from current state + inputs (same-cycle effect).
//  - reset high: pc_write=0, if_id_write=0, if_flush=1, id_flush=1, irq_to_id=0; next edge
//    clears irq_pending, counters, FSM -> IDLE.
//  - Default (no event): pc_write=1, if_id_write=1, flushes=0, irq_to_id=0.
//  - Priority per cycle, highest first:
//    1 mem_busy: pc_write=0, if_id_write=0, if_flush=0, id_flush=0; FSM, drain counter held.
//    2 ex_branch_taken: pc_write=1, if_flush=1, id_flush=1; load_use ignored; drain restarts.
//    3 FSM in INJECT: pc_write=1, if_flush=1, irq_to_id=1 (one cycle only).
//    4 id_exception or id_jump: pc_write=1, if_flush=1; drain counter restarts.
//    5 load_use: pc_write=0, if_id_write=0, id_flush=1 (exactly one bubble per assertion).
//  - IRQ FSM states: IDLE, DRAIN, INJECT, KWAIT.
//    IDLE  : irq_req=1 & kernel_mode=0 -> DRAIN, set irq_pending, drain cnt=0.
//    DRAIN : cnt increments on cycles with no priority-2/4 event and not mem_busy; event
//            resets cnt to 0; cnt==DRAIN_CYCLES-1 on a counting cycle -> INJECT.
//    INJECT: one non-busy cycle; clears irq_pending -> KWAIT. If mem_busy, stays.
//            If ex_branch_taken coincides, injection aborts -> DRAIN, cnt=0, pending kept.
//    KWAIT : ignore irq_req until kernel_mode=1 seen then kernel_mode=0 (handler return)
//            -> IDLE. irq_req held high through return re-enters DRAIN next cycle.
//  - irq_req arriving with kernel_mode=1 is not latched (kernel non-interruptible).
//  - Counters: +1 per qualifying cycle, wrap at 2^CNT_W to 0; a mem_busy cycle counts as
//    a stall. No counting while reset high.
// STRUCTURE
//  - Shared package: IRQ FSM state enum (2-bit), DRAIN_CYCLES default, control-vector
//    constants CTRL_RUN/CTRL_FREEZE/CTRL_BUBBLE/CTRL_REDIRECT as {pc_w,ifid_w,if_fl,id_fl}.
//  - One sub-module: irq_entry_fsm (IDLE/DRAIN/INJECT/KWAIT + drain counter), outputs
//    inject, irq_pending; top does priority merge and counters.
// TESTING
//  - load_use=1 for 1 cycle -> pc_write=0, if_id_write=0, id_flush=1 that cycle; stall_count=1.
//  - load_use & ex_branch_taken same cycle -> pc_write=1, if_flush=1, id_flush=1; stall_count=0.
//  - irq_req=1, kernel_mode=0, quiet pipe, DRAIN_CYCLES=2 -> irq_to_id=1 exactly on 4th cycle
//    after request edge (IDLE->DRAIN, 2 drain, INJECT), irq_pending 1 then 0.
//  - irq pending, id_jump every cycle for 5 cycles -> no injection; inject 2 cycles after last jump.
//  - mem_busy=1 for 3 cycles during DRAIN -> all controls frozen, cnt held, stall_count+=3.
//  - reset asserted mid-INJECT -> next cycle irq_pending=0, counters=0, irq_to_id=0, FSM IDLE.

Source files
------------

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard sequencer.
// Control vectors are packed as {pc_w, ifid_w, if_fl, id_fl}.
package pipe_hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        IRQ_IDLE   = 2'd0,
        IRQ_DRAIN  = 2'd1,
        IRQ_INJECT = 2'd2,
        IRQ_KWAIT  = 2'd3
    } irq_state_t;

    localparam int DRAIN_CYCLES_DEF = 2;
    localparam int CNT_W_DEF        = 32;

    typedef logic [3:0] ctrl_t;

    localparam ctrl_t CTRL_RUN      = 4'b1100;
    localparam ctrl_t CTRL_FREEZE   = 4'b0000;
    localparam ctrl_t CTRL_BUBBLE   = 4'b0001;
    localparam ctrl_t CTRL_REDIRECT = 4'b1110;
    localparam ctrl_t CTRL_BRANCH   = 4'b1111;
    localparam ctrl_t CTRL_RESET    = 4'b0011;

endpackage

// File: rtl/pipe_hazard_ctrl_irq_entry_fsm.sv
// Interrupt entry sequencer: latch, drain redirects, inject once,
// then wait for the handler to enter and leave kernel mode.
module irq_entry_fsm
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic mem_busy,
    input  logic ex_redirect,
    input  logic id_redirect,
    input  logic irq_req,
    input  logic kernel_mode,
    output logic inject,
    output logic irq_pending
);

    localparam int CW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(DRAIN_CYCLES - 1);

    irq_state_t    state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          pend_n;
    logic          kseen, kseen_n;

    // State register with synchronous reset to IDLE
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IRQ_IDLE;
            cnt         <= '0;
            irq_pending <= 1'b0;
            kseen       <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            irq_pending <= pend_n;
            kseen       <= kseen_n;
        end
    end

    // Next-state logic; a busy memory freezes every field
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        pend_n  = irq_pending;
        kseen_n = kseen;
        inject  = (state == IRQ_INJECT);
        if (!mem_busy) begin
            unique case (state)
                IRQ_IDLE: begin
                    if (irq_req && !kernel_mode) begin
                        state_n = IRQ_DRAIN;
                        cnt_n   = '0;
                        pend_n  = 1'b1;
                    end
                end
                IRQ_DRAIN: begin
                    if (ex_redirect || id_redirect) begin
                        cnt_n = '0;
                    end else if (cnt == LAST) begin
                        state_n = IRQ_INJECT;
                    end else begin
                        cnt_n = cnt + CW'(1);
                    end
                end
                IRQ_INJECT: begin
                    if (ex_redirect) begin
                        state_n = IRQ_DRAIN;
                        cnt_n   = '0;
                    end else begin
                        state_n = IRQ_KWAIT;
                        pend_n  = 1'b0;
                        kseen_n = 1'b0;
                    end
                end
                IRQ_KWAIT: begin
                    if (kernel_mode) begin
                        kseen_n = 1'b1;
                    end else if (kseen) begin
                        state_n = IRQ_IDLE;
                        kseen_n = 1'b0;
                    end
                end
                default: state_n = IRQ_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline stall/flush/redirect sequencer with interrupt entry
// and stall/flush performance counters.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF,
    parameter int CNT_W        = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_use,
    input  logic             id_jump,
    input  logic             id_exception,
    input  logic             ex_branch_taken,
    input  logic             mem_busy,
    input  logic             irq_req,
    input  logic             kernel_mode,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_flush,
    output logic             id_flush,
    output logic             irq_to_id,
    output logic             irq_pending,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    ctrl_t ctrl;
    logic  inject;
    logic  bubble;
    logic  lu_done;

    irq_entry_fsm #(
        .DRAIN_CYCLES(DRAIN_CYCLES)
    ) u_irq (
        .clk        (clk),
        .reset      (reset),
        .mem_busy   (mem_busy),
        .ex_redirect(ex_branch_taken),
        .id_redirect(id_jump | id_exception),
        .irq_req    (irq_req),
        .kernel_mode(kernel_mode),
        .inject     (inject),
        .irq_pending(irq_pending)
    );

    // Priority merge of all hazard sources into one control vector
    always_comb begin
        ctrl      = CTRL_RUN;
        irq_to_id = 1'b0;
        bubble    = 1'b0;
        if (reset) begin
            ctrl = CTRL_RESET;
        end else if (mem_busy) begin
            ctrl = CTRL_FREEZE;
        end else if (ex_branch_taken) begin
            ctrl = CTRL_BRANCH;
        end else if (inject) begin
            ctrl      = CTRL_REDIRECT;
            irq_to_id = 1'b1;
        end else if (id_exception || id_jump) begin
            ctrl = CTRL_REDIRECT;
        end else if (load_use && !lu_done) begin
            ctrl   = CTRL_BUBBLE;
            bubble = 1'b1;
        end
    end

    assign {pc_write, if_id_write, if_flush, id_flush} = ctrl;

    // One bubble per load_use assertion; re-arms when it drops
    always_ff @(posedge clk) begin
        if (reset) begin
            lu_done <= 1'b0;
        end else if (!load_use) begin
            lu_done <= 1'b0;
        end else if (bubble) begin
            lu_done <= 1'b1;
        end
    end

    // Wrapping stall and flush counters
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            if (!pc_write) begin
                stall_count <= stall_count + CNT_W'(1);
            end
            if (if_flush) begin
                flush_count <= flush_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: a cycle model plus
// directed scenarios with hand-computed expectations.
module tb_pipe_hazard_ctrl;

    localparam int DC = 2;

    logic        clk;
    logic        reset;
    logic        load_use;
    logic        id_jump;
    logic        id_exception;
    logic        ex_branch_taken;
    logic        mem_busy;
    logic        irq_req;
    logic        kernel_mode;
    logic        pc_write;
    logic        if_id_write;
    logic        if_flush;
    logic        id_flush;
    logic        irq_to_id;
    logic        irq_pending;
    logic [31:0] stall_count;
    logic [31:0] flush_count;

    int nchk = 0;
    int nerr = 0;

    pipe_hazard_ctrl #(
        .DRAIN_CYCLES(DC),
        .CNT_W(32)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .load_use       (load_use),
        .id_jump        (id_jump),
        .id_exception   (id_exception),
        .ex_branch_taken(ex_branch_taken),
        .mem_busy       (mem_busy),
        .irq_req        (irq_req),
        .kernel_mode    (kernel_mode),
        .pc_write       (pc_write),
        .if_id_write    (if_id_write),
        .if_flush       (if_flush),
        .id_flush       (id_flush),
        .irq_to_id      (irq_to_id),
        .irq_pending    (irq_pending),
        .stall_count    (stall_count),
        .flush_count    (flush_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit          armed = 0;
    bit          m_lat = 0;
    bit          m_hand = 0;
    bit          m_kseen = 0;
    bit          m_luused = 0;
    int          m_quiet = 0;
    logic [31:0] m_stall = 0;
    logic [31:0] m_flush = 0;

    logic       e_pc, e_ifid, e_iff, e_idf, e_irq, e_bub, e_due;

    always_comb begin
        e_due = m_lat && (m_quiet >= DC);
        e_pc  = 1'b1;
        e_ifid = 1'b1;
        e_iff = 1'b0;
        e_idf = 1'b0;
        e_irq = 1'b0;
        e_bub = 1'b0;
        if (reset) begin
            e_pc = 0; e_ifid = 0; e_iff = 1; e_idf = 1;
        end else if (mem_busy) begin
            e_pc = 0; e_ifid = 0;
        end else if (ex_branch_taken) begin
            e_iff = 1; e_idf = 1;
        end else if (e_due) begin
            e_iff = 1; e_irq = 1;
        end else if (id_jump || id_exception) begin
            e_iff = 1;
        end else if (load_use && !m_luused) begin
            e_pc = 0; e_ifid = 0; e_idf = 1; e_bub = 1;
        end
    end

    always @(posedge clk) begin
        if (reset) begin
            armed    <= 1;
            m_lat    <= 0;
            m_hand   <= 0;
            m_kseen  <= 0;
            m_luused <= 0;
            m_quiet  <= 0;
            m_stall  <= 0;
            m_flush  <= 0;
        end else begin
            if (!e_pc) m_stall <= m_stall + 1;
            if (e_iff) m_flush <= m_flush + 1;
            if (!load_use) m_luused <= 0;
            else if (e_bub) m_luused <= 1;
            if (!mem_busy) begin
                if (m_hand) begin
                    if (kernel_mode) m_kseen <= 1;
                    else if (m_kseen) begin
                        m_hand  <= 0;
                        m_kseen <= 0;
                    end
                end else if (!m_lat) begin
                    if (irq_req && !kernel_mode) begin
                        m_lat   <= 1;
                        m_quiet <= 0;
                    end
                end else if (e_due) begin
                    if (ex_branch_taken) m_quiet <= 0;
                    else begin
                        m_lat   <= 0;
                        m_hand  <= 1;
                        m_kseen <= 0;
                    end
                end else if (ex_branch_taken || id_jump || id_exception) begin
                    m_quiet <= 0;
                end else begin
                    m_quiet <= m_quiet + 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            chk("m_pc_write", {31'd0, pc_write}, {31'd0, e_pc});
            chk("m_if_id_write", {31'd0, if_id_write}, {31'd0, e_ifid});
            chk("m_if_flush", {31'd0, if_flush}, {31'd0, e_iff});
            chk("m_id_flush", {31'd0, id_flush}, {31'd0, e_idf});
            chk("m_irq_to_id", {31'd0, irq_to_id}, {31'd0, e_irq});
            chk("m_irq_pending", {31'd0, irq_pending}, {31'd0, m_lat});
            chk("m_stall_count", stall_count, m_stall);
            chk("m_flush_count", flush_count, m_flush);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic drv(input bit r, input bit lu, input bit jp,
                       input bit ex, input bit br, input bit mb,
                       input bit iq, input bit km);
        reset = r;
        load_use = lu;
        id_jump = jp;
        id_exception = ex;
        ex_branch_taken = br;
        mem_busy = mb;
        irq_req = iq;
        kernel_mode = km;
    endtask

    task automatic look();
        @(negedge clk);
        #1;
    endtask

    task automatic go();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drv(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        drv(1, 0, 0, 0, 0, 0, 0, 0);
        look();
        go();
    endtask

    function automatic logic [31:0] b(input logic v);
        return {31'd0, v};
    endfunction

    initial begin
        // reset values
        drv(1, 0, 0, 0, 0, 0, 0, 0);
        look();
        chk("rst_pc_write", b(pc_write), 0);
        chk("rst_if_id_write", b(if_id_write), 0);
        chk("rst_if_flush", b(if_flush), 1);
        chk("rst_id_flush", b(id_flush), 1);
        chk("rst_irq_to_id", b(irq_to_id), 0);
        go();
        idle();
        look();
        chk("rst_stall", stall_count, 0);
        chk("rst_flush", flush_count, 0);
        chk("rst_pending", b(irq_pending), 0);
        chk("run_pc_write", b(pc_write), 1);
        go();

        // single load-use bubble
        drv(0, 1, 0, 0, 0, 0, 0, 0);
        look();
        chk("lu_pc_write", b(pc_write), 0);
        chk("lu_if_id_write", b(if_id_write), 0);
        chk("lu_id_flush", b(id_flush), 1);
        go();
        idle();
        look();
        chk("lu_stall", stall_count, 1);
        go();

        // load-use held two cycles: one bubble only
        drv(0, 1, 0, 0, 0, 0, 0, 0);
        look();
        chk("lu2_first_pc", b(pc_write), 0);
        go();
        look();
        chk("lu2_second_pc", b(pc_write), 1);
        go();
        idle();
        look();
        chk("lu2_stall", stall_count, 2);
        go();

        // load-use with branch taken
        do_reset();
        drv(0, 1, 0, 0, 1, 0, 0, 0);
        look();
        chk("lubr_pc_write", b(pc_write), 1);
        chk("lubr_if_flush", b(if_flush), 1);
        chk("lubr_id_flush", b(id_flush), 1);
        go();
        idle();
        look();
        chk("lubr_stall", stall_count, 0);
        chk("lubr_flush", flush_count, 1);
        go();

        // quiet IRQ entry, then handler return with irq still high
        do_reset();
        drv(0, 0, 0, 0, 0, 0, 1, 0);
        look();
        chk("irq_c1_inj", b(irq_to_id), 0);
        chk("irq_c1_pend", b(irq_pending), 0);
        go();
        for (int i = 2; i <= 3; i++) begin
            look();
            chk("irq_drain_inj", b(irq_to_id), 0);
            chk("irq_drain_pend", b(irq_pending), 1);
            go();
        end
        look();
        chk("irq_c4_inj", b(irq_to_id), 1);
        chk("irq_c4_pend", b(irq_pending), 1);
        chk("irq_c4_if_flush", b(if_flush), 1);
        chk("irq_c4_id_flush", b(id_flush), 0);
        go();
        look();
        chk("irq_c5_inj", b(irq_to_id), 0);
        chk("irq_c5_pend", b(irq_pending), 0);
        go();
        drv(0, 0, 0, 0, 0, 0, 1, 1);
        look();
        chk("irq_kern_pend", b(irq_pending), 0);
        go();
        drv(0, 0, 0, 0, 0, 0, 1, 0);
        look();
        chk("irq_ret_pend", b(irq_pending), 0);
        go();
        look();
        chk("irq_idle_pend", b(irq_pending), 0);
        go();
        look();
        chk("irq_reenter_pend", b(irq_pending), 1);
        go();

        // jumps hold off injection
        do_reset();
        drv(0, 0, 0, 0, 0, 0, 1, 0);
        look();
        go();
        for (int i = 0; i < 5; i++) begin
            drv(0, 0, 1, 0, 0, 0, 0, 0);
            look();
            chk("jmp_inj", b(irq_to_id), 0);
            chk("jmp_if_flush", b(if_flush), 1);
            go();
        end
        idle();
        look();
        chk("jmp_after1_inj", b(irq_to_id), 0);
        go();
        look();
        chk("jmp_after2_inj", b(irq_to_id), 0);
        go();
        look();
        chk("jmp_after3_inj", b(irq_to_id), 1);
        go();
        look();
        chk("jmp_done_pend", b(irq_pending), 0);
        chk("jmp_flush", flush_count, 6);
        go();

        // mem_busy freezes drain
        do_reset();
        drv(0, 0, 0, 0, 0, 0, 1, 0);
        look();
        go();
        idle();
        look();
        go();
        for (int i = 0; i < 3; i++) begin
            drv(0, 1, 1, 0, 0, 1, 0, 0);
            look();
            chk("busy_pc", b(pc_write), 0);
            chk("busy_ifid", b(if_id_write), 0);
            chk("busy_iff", b(if_flush), 0);
            chk("busy_idf", b(id_flush), 0);
            chk("busy_inj", b(irq_to_id), 0);
            go();
        end
        idle();
        look();
        chk("busy_stall", stall_count, 3);
        chk("busy_post_inj", b(irq_to_id), 0);
        go();
        look();
        chk("busy_inject", b(irq_to_id), 1);
        go();

        // reset asserted in the INJECT cycle
        do_reset();
        drv(0, 0, 0, 0, 0, 0, 1, 0);
        look();
        go();
        drv(0, 0, 1, 0, 0, 0, 0, 0);
        look();
        go();
        drv(0, 1, 0, 0, 0, 0, 0, 0);
        look();
        go();
        idle();
        look();
        chk("ri_pre_inj", b(irq_to_id), 0);
        go();
        drv(1, 0, 0, 0, 0, 0, 0, 0);
        look();
        chk("ri_rst_inj", b(irq_to_id), 0);
        chk("ri_rst_pend", b(irq_pending), 1);
        chk("ri_rst_stall", stall_count, 1);
        go();
        idle();
        for (int i = 0; i < 3; i++) begin
            look();
            chk("ri_post_pend", b(irq_pending), 0);
            chk("ri_post_inj", b(irq_to_id), 0);
            chk("ri_post_stall", stall_count, 0);
            chk("ri_post_flush", flush_count, 0);
            go();
        end

        // IRQ while in kernel mode is ignored
        do_reset();
        drv(0, 0, 0, 0, 0, 0, 1, 1);
        look();
        go();
        look();
        go();
        idle();
        look();
        chk("kern_pend", b(irq_pending), 0);
        go();

        // branch aborts injection
        do_reset();
        drv(0, 0, 0, 0, 0, 0, 1, 0);
        look();
        go();
        idle();
        look();
        go();
        look();
        go();
        drv(0, 0, 0, 0, 1, 0, 0, 0);
        look();
        chk("abort_inj", b(irq_to_id), 0);
        chk("abort_idf", b(id_flush), 1);
        go();
        idle();
        look();
        chk("abort_pend", b(irq_pending), 1);
        go();
        look();
        chk("abort_wait_inj", b(irq_to_id), 0);
        go();
        look();
        chk("abort_reinject", b(irq_to_id), 1);
        go();
        look();
        go();

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
